output_periph_bank: RTL and testbench

- Parametrised, registered output-peripheral bank for the single-cycle core's memory-mapped IO region.
- Replaces the fixed 11-channel, byte-array combinational mapping with:
  - CH_NUM 32-bit output channels.
  - Byte-enabled stores.
  - One-cycle registered readback.
  - Optional shadow/commit double-buffering.
  - Per-channel hardware blink.
- Sits beside data memory on the LSU store/load path; drives the HEX/LEDR/LEDG/LCD pins.

---
 rtl/output_periph_bank_pkg.sv | 55 +++++
 rtl/output_periph_bank_if.sv | 33 +++
 rtl/output_periph_bank_blink_prescaler.sv | 30 +++
 rtl/output_periph_bank.sv | 139 +++++++++++++
 tb/tb_output_periph_bank.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/output_periph_bank_pkg.sv
// -----------------------------------------------------------------------------
// periph_pkg
// Shared constants, decode types and helpers for the output peripheral bank.
//   - CTRL register bit positions
//   - CTRL / BLINK byte offsets relative to BASE_ADR
//   - Default channel assignment (HEX0..HEX7, LEDR, LEDG, LCD)
//   - Address-decode result enum
//   - Byte-lane merge helper used for every byte-enabled store
// -----------------------------------------------------------------------------
package periph_pkg;

   localparam int CTRL_SHADOW_EN_BIT = 0;
   localparam int CTRL_COMMIT_BIT    = 1;

   localparam int HEX0 = 0;
   localparam int HEX1 = 1;
   localparam int HEX2 = 2;
   localparam int HEX3 = 3;
   localparam int HEX4 = 4;
   localparam int HEX5 = 5;
   localparam int HEX6 = 6;
   localparam int HEX7 = 7;
   localparam int LEDR = 8;
   localparam int LEDG = 9;
   localparam int LCD  = 10;

   typedef enum logic [1:0] {
      HIT_CH,
      HIT_CTRL,
      HIT_BLINK,
      MISS
   } dec_e;

   // CTRL sits directly after the last channel slot.
   function automatic int ctrl_off(input int ch_num, input int stride);
      return ch_num * stride;
   endfunction

   function automatic int blink_off(input int ch_num, input int stride);
      return ctrl_off(ch_num, stride) + 4;
   endfunction

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  bmask);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (bmask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/output_periph_bank_if.sv
// -----------------------------------------------------------------------------
// output_periph_bank_if
// LSU-side load/store bus of the output peripheral bank.
//   addr_i   byte address (bits [1:0] ignored for decode)
//   wdata_i  lane-aligned store data
//   bmask_i  byte-lane enables
//   st_en_i  store strobe
//   ld_en_i  load strobe
//   rdata_o  registered read data
//   rvalid_o read data valid, one cycle after ld_en_i
// master = core/LSU side, slave = peripheral bank.
// -----------------------------------------------------------------------------
interface output_periph_bank_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       wdata_i;
   logic [3:0]        bmask_i;
   logic              st_en_i;
   logic              ld_en_i;
   logic [31:0]       rdata_o;
   logic              rvalid_o;

   modport master (
      output addr_i, wdata_i, bmask_i, st_en_i, ld_en_i,
      input  rdata_o, rvalid_o
   );

   modport slave (
      input  addr_i, wdata_i, bmask_i, st_en_i, ld_en_i,
      output rdata_o, rvalid_o
   );
endinterface

// File: rtl/output_periph_bank_blink_prescaler.sv
// -----------------------------------------------------------------------------
// blink_prescaler
// Free-running 0..BLINK_DIV-1 counter; phase_o toggles on each wrap.
//   clk_i    system clock
//   rst_i    asynchronous active-high reset (counter 0, phase_o = 1)
//   phase_o  blink phase, 1 = on
// -----------------------------------------------------------------------------
module blink_prescaler #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic phase_o
);
   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt     <= '0;
         phase_o <= 1'b1;
      end else if (cnt == CW'(BLINK_DIV - 1)) begin
         cnt     <= '0;
         phase_o <= ~phase_o;
      end else begin
         cnt     <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/output_periph_bank.sv
// -----------------------------------------------------------------------------
// output_periph_bank
// Registered, byte-enabled output peripheral bank on the LSU path.
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   bus            load/store bus (slave modport)
//   io_o           CH_NUM x 32-bit channel outputs, channel k at [32k+31:32k]
//   blink_phase_o  current blink phase (1 = on)
// Each channel has a software-visible shadow register and a pin-driving
// active register. With SHADOW_EN clear both are written together; with it
// set, writes collect in shadow until a COMMIT copies all of them at once.
// CH_NUM is limited to 32 because BLINK is a single 32-bit register.
// -----------------------------------------------------------------------------
module output_periph_bank
   import periph_pkg::*;
#(
   parameter int              CH_NUM    = 11,
   parameter int              ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADR = 12'h800,
   parameter int              STRIDE    = 16,
   parameter int              BLINK_DIV = 25_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output_periph_bank_if.slave   bus,
   output logic [CH_NUM*32-1:0]  io_o,
   output logic                  blink_phase_o
);
   localparam int SH         = $clog2(STRIDE);
   localparam int CIW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int CTRL_WORD  = ctrl_off(CH_NUM, STRIDE) / 4;
   localparam int BLINK_WORD = blink_off(CH_NUM, STRIDE) / 4;
   localparam logic [31:0] BLINK_MASK =
      (CH_NUM >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CH_NUM) - 64'd1);

   logic [31:0] shadow [CH_NUM];
   logic [31:0] active [CH_NUM];
   logic        shadow_en;
   logic [31:0] blink_q;

   logic [29:0]    offw;
   dec_e           dec;
   logic [CIW-1:0] ch_idx;
   logic [31:0]    wr_merged;
   logic [31:0]    rd_mux;

   logic [31:0] rdata_p1;
   logic        vld_p1;

   // ---- stage 0: address decode and read mux ----
   always_comb begin
      // Word offset from BASE_ADR; addresses below the base wrap to a huge
      // offset and therefore fall through to MISS.
      offw   = 30'((32'(bus.addr_i) - 32'(BASE_ADR)) >> 2);
      dec    = MISS;
      ch_idx = '0;
      if (offw < 30'(CTRL_WORD)) begin
         // Only the first word of each stride slot is a channel register.
         if ((32'(offw) & 32'(STRIDE / 4 - 1)) == 32'd0) begin
            dec    = HIT_CH;
            ch_idx = CIW'(offw >> (SH - 2));
         end
      end else if (offw == 30'(CTRL_WORD)) begin
         dec = HIT_CTRL;
      end else if (offw == 30'(BLINK_WORD)) begin
         dec = HIT_BLINK;
      end
   end

   always_comb begin
      wr_merged = lane_merge(shadow[ch_idx], bus.wdata_i, bus.bmask_i);
      rd_mux    = '0;
      case (dec)
         HIT_CH:    rd_mux = shadow[ch_idx];
         HIT_CTRL:  rd_mux[CTRL_SHADOW_EN_BIT] = shadow_en;
         HIT_BLINK: rd_mux = blink_q;
         default:   rd_mux = '0;
      endcase
   end

   // ---- stage 1: register state update and registered read response ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < CH_NUM; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
         shadow_en <= 1'b0;
         blink_q   <= '0;
         rdata_p1  <= '0;
         vld_p1    <= 1'b0;
      end else begin
         vld_p1 <= bus.ld_en_i;
         // Read mux sees pre-store state, so a same-cycle load and store
         // to one address returns the old value.
         if (bus.ld_en_i) rdata_p1 <= rd_mux;

         if (bus.st_en_i) begin
            case (dec)
               HIT_CH: begin
                  shadow[ch_idx] <= wr_merged;
                  // Built from shadow, so a write after SHADOW_EN is cleared
                  // also exposes any previously pending bytes of the channel.
                  if (!shadow_en) active[ch_idx] <= wr_merged;
               end
               HIT_CTRL: begin
                  if (bus.bmask_i[0]) begin
                     shadow_en <= bus.wdata_i[CTRL_SHADOW_EN_BIT];
                     if (bus.wdata_i[CTRL_COMMIT_BIT]) begin
                        for (int k = 0; k < CH_NUM; k++) active[k] <= shadow[k];
                     end
                  end
               end
               HIT_BLINK: begin
                  blink_q <= lane_merge(blink_q, bus.wdata_i, bus.bmask_i) & BLINK_MASK;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rdata_o  = rdata_p1;
   assign bus.rvalid_o = vld_p1;

   blink_prescaler #(
      .BLINK_DIV (BLINK_DIV)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .phase_o (blink_phase_o)
   );

   // ---- output: blanking during the off phase of blinking channels ----
   for (genvar k = 0; k < CH_NUM; k++) begin : g_io
      assign io_o[32*k +: 32] = (blink_q[k] && !blink_phase_o) ? 32'd0 : active[k];
   end

endmodule

// File: tb/tb_output_periph_bank.sv
// -----------------------------------------------------------------------------
// tb_output_periph_bank
// Directed bench for output_periph_bank (11 channels, base 0x800, stride 16,
// BLINK_DIV = 4). CTRL is at 0x8B0, BLINK at 0x8B4.
// -----------------------------------------------------------------------------
module tb_output_periph_bank;
   localparam int CH = 11;

   localparam logic [11:0] A_CTRL  = 12'h8B0;
   localparam logic [11:0] A_BLINK = 12'h8B4;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH*32-1:0]  io;
   logic              phase;

   int n_run  = 0;
   int n_fail = 0;
   int edges;

   output_periph_bank_if #(.ADDR_W(12)) bus ();

   output_periph_bank #(
      .CH_NUM    (CH),
      .ADDR_W    (12),
      .BASE_ADR  (12'h800),
      .STRIDE    (16),
      .BLINK_DIV (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .bus           (bus),
      .io_o          (io),
      .blink_phase_o (phase)
   );

   always #5 clk = ~clk;

   // Independent blink model: phase starts at 1 and toggles every 4 edges.
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   function automatic logic model_phase();
      return ((edges / 4) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic [31:0] chan(input int k);
      return io[32*k +: 32];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.addr_i  = a;
      bus.wdata_i = d;
      bus.bmask_i = m;
      bus.st_en_i = 1'b1;
      @(posedge clk);
      #1;
      bus.st_en_i = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      bus.addr_i  = a;
      bus.ld_en_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ld_en_i = 1'b0;
      check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'd1);
      check({tag, ".rdata"}, bus.rdata_o, exp);
   endtask

   initial begin
      rst         = 1'b1;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.bmask_i = '0;
      bus.st_en_i = 1'b0;
      bus.ld_en_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst.io0", chan(0), 32'h0);
      check("rst.rvalid", 32'(bus.rvalid_o), 32'd0);
      check("rst.rdata", bus.rdata_o, 32'h0);
      check("rst.phase", 32'(phase), 32'd1);

      // 1: full word store and readback
      store(12'h800, 32'hDEADBEEF, 4'hF);
      check("t1.io0", chan(0), 32'hDEADBEEF);
      load_chk("t1.ld0", 12'h800, 32'hDEADBEEF);
      @(posedge clk); #1;
      check("t1.rvalid_drop", 32'(bus.rvalid_o), 32'd0);
      check("t1.rdata_hold", bus.rdata_o, 32'hDEADBEEF);

      // 2: byte stores and misses
      store(12'h810, 32'h00120000, 4'b0100);
      check("t2.io1", chan(1), 32'h00120000);
      store(12'h800, 32'h000000AA, 4'b0001);
      check("t2.io0_lane0", chan(0), 32'hDEADBEAA);
      store(12'h800, 32'hFFFFFFFF, 4'b0000);
      check("t2.io0_nomask", chan(0), 32'hDEADBEAA);
      store(12'h8C0, 32'hFFFFFFFF, 4'hF);
      check("t2.miss_io0", chan(0), 32'hDEADBEAA);
      check("t2.miss_io1", chan(1), 32'h00120000);
      check("t2.miss_io2", chan(2), 32'h0);
      load_chk("t2.ld_miss", 12'h8C0, 32'h0);
      store(12'h804, 32'h12345678, 4'hF);
      check("t2.gap_io0", chan(0), 32'hDEADBEAA);
      load_chk("t2.ld_gap", 12'h804, 32'h0);
      load_chk("t2.ld_below", 12'h7F0, 32'h0);

      // 3: shadow mode and commit
      store(A_CTRL, 32'h1, 4'hF);
      store(12'h830, 32'h55, 4'hF);
      store(12'h840, 32'hAA, 4'hF);
      check("t3.io3_pending", chan(3), 32'h0);
      check("t3.io4_pending", chan(4), 32'h0);
      load_chk("t3.ld3", 12'h830, 32'h55);
      load_chk("t3.ld4", 12'h840, 32'hAA);
      store(A_CTRL, 32'h3, 4'b0010);
      check("t3.lane1_only_io3", chan(3), 32'h0);
      store(A_CTRL, 32'h3, 4'hF);
      check("t3.io3_commit", chan(3), 32'h55);
      check("t3.io4_commit", chan(4), 32'hAA);
      load_chk("t3.ld_ctrl", A_CTRL, 32'h1);
      store(A_CTRL, 32'h0, 4'hF);
      load_chk("t3.ld_ctrl_off", A_CTRL, 32'h0);

      // 4: blink on CH9 only
      store(12'h890, 32'hFF, 4'hF);
      store(12'h880, 32'h0F, 4'hF);
      store(A_BLINK, 32'h200, 4'hF);
      for (int i = 0; i < 12; i++) begin
         check("t4.phase", 32'(phase), 32'(model_phase()));
         check("t4.io9", chan(9), model_phase() ? 32'hFF : 32'h0);
         check("t4.io8", chan(8), 32'h0F);
         @(posedge clk); #1;
      end
      load_chk("t4.ld_blink", A_BLINK, 32'h200);
      store(A_BLINK, 32'hFFFFFFFF, 4'hF);
      load_chk("t4.ld_blink_mask", A_BLINK, 32'h7FF);
      store(A_BLINK, 32'h0, 4'hF);

      // 5: async reset mid-load with pending shadows
      store(A_CTRL, 32'h1, 4'hF);
      store(12'h850, 32'h1234, 4'hF);
      bus.addr_i  = 12'h850;
      bus.ld_en_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < CH; k++) check($sformatf("t5.io%0d", k), chan(k), 32'h0);
      check("t5.rvalid", 32'(bus.rvalid_o), 32'd0);
      check("t5.rdata", bus.rdata_o, 32'h0);
      check("t5.phase", 32'(phase), 32'd1);
      bus.ld_en_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5.rvalid_after", 32'(bus.rvalid_o), 32'd0);
      store(A_CTRL, 32'h2, 4'hF);
      check("t5.io5_nocommit", chan(5), 32'h0);
      load_chk("t5.ld5", 12'h850, 32'h0);
      load_chk("t5.ld_ctrl", A_CTRL, 32'h0);

      // 6: same-cycle load and store to CH0
      bus.addr_i  = 12'h800;
      bus.wdata_i = 32'h11223344;
      bus.bmask_i = 4'hF;
      bus.st_en_i = 1'b1;
      bus.ld_en_i = 1'b1;
      @(posedge clk); #1;
      bus.st_en_i = 1'b0;
      bus.ld_en_i = 1'b0;
      check("t6.rvalid", 32'(bus.rvalid_o), 32'd1);
      check("t6.rdata_old", bus.rdata_o, 32'h0);
      check("t6.io0", chan(0), 32'h11223344);
      load_chk("t6.ld_new", 12'h800, 32'h11223344);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
